ahblite_regbank_slave: RTL and testbench
========================================

Name: ahblite_regbank_slave

Overview:
- AHB-Lite responder: a bank of NUM_REGS 32-bit registers with a programmable number of data-phase wait states and a two-cycle ERROR response.
- Hangs off one peripheral port of the SoC AHB-Lite interconnect and is selected by the decoder's HSEL.
- Serves as the general-purpose control/status peripheral and as the reference target for interconnect and HREADY/HRESP verification.

Parameters:
- WAIT_STATES, 1, number of HREADYOUT-low cycles inserted in each OKAY data phase; legal range 0..7.
- NUM_REGS, 8, number of 32-bit registers; power of two, 2..16. Index NUM_REGS-1 is the read-only STATUS register.

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  asynchronous reset, active-high
- HSEL  in  1  slave select from the interconnect decoder
- HADDR  in  32  address; HADDR[11:2] is the register index, HADDR[1:0] selects byte lanes
- HTRANS  in  2  transfer type
- HSIZE  in  3  transfer size
- HWRITE  in  1  1 = write
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  global bus ready (muxed HREADYOUT)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  1 = ERROR
- HRDATA  out  32  read data
- STATUS_IN  in  32  value returned on reads of register NUM_REGS-1
- REG0_OUT  out  32  live value of register 0

Behaviour:
- Reset (async, HRESET=1):
  - registers = 0, FSM = IDLE, wait counter = 0.
  - HREADYOUT = 1, HRESP = 0, HRDATA = 0, REG0_OUT = 0.
  - Reset asserted mid-transfer aborts it; no write is committed.
- Accept:
  - An address phase is accepted on a rising edge with HSEL=1, HTRANS[1]=1 and HREADY=1.
  - On accept, latch index, HADDR[1:0], HSIZE and HWRITE, plus an error flag.
  - IDLE/BUSY transfers, HSEL=0 or HREADY=0 are ignored: no state change, OKAY with zero wait.
- Error conditions (any one sets the error flag):
  - HSIZE > 2.
  - Halfword with HADDR[0]=1.
  - Word with HADDR[1:0] != 0.
  - HADDR[11:2] >= NUM_REGS.
  - Write to index NUM_REGS-1.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0.
    - Accepted transfer with error flag -> ERR1.
    - Accepted OKAY transfer with WAIT_STATES>0 -> WAIT, counter = WAIT_STATES.
    - Accepted OKAY transfer with WAIT_STATES=0 -> stay in IDLE; the following cycle is the completing data-phase cycle.
  - WAIT: HREADYOUT=0, HRESP=0; counter decrements each cycle. When the counter reaches 1, the next cycle is the completing data-phase cycle (HREADYOUT=1), then IDLE behaviour resumes.
  - ERR1: HREADYOUT=0, HRESP=1; always -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; -> IDLE.
  - An error is never preceded by wait states. Registers are never modified by an errored transfer.
- Completing cycle:
  - A write commits HWDATA on this edge: little-endian byte lanes, where a byte writes lane HADDR[1:0] and a halfword writes lanes {HADDR[1],0} and {HADDR[1],1}. Unselected lanes are unchanged.
  - A new address phase may be accepted in this same cycle (pipelined back-to-back); ERR2 likewise accepts.
- HRDATA:
  - During a read data phase (WAIT and completing cycle), HRDATA = reg[latched index], or STATUS_IN for index NUM_REGS-1, presented as the full 32-bit word regardless of size.
  - Otherwise HRDATA = 0.
- Write followed by read of the same register back-to-back returns the newly written value. The write commits before the read data phase begins, so no forwarding is needed.
- Sizes: data-phase OKAY length = WAIT_STATES+1 cycles; the wait counter is 3 bits wide.

Test Plan:
- Reset: HRESET pulse mid-WAIT of a write of 0x12345678 to reg0 -> HREADYOUT=1, HRESP=0, REG0_OUT=0 immediately; after release, reading reg0 returns 0.
- Wait timing (WAIT_STATES=1): word write 0xDEADBEEF to 0x004, then word read of 0x004 back-to-back -> each data phase has HREADYOUT 0,1; read returns 0xDEADBEEF; no bubble between transfers.
- Byte lanes: word write 0xFFFFFFFF to reg2, byte write 0x5A to 0x00A, halfword write 0x1234 to 0x008 -> reg2 reads 0xFF5A1234.
- Errors:
  - Write to index NUM_REGS-1 (0x01C) -> HREADYOUT 0 then 1 with HRESP=1 both cycles; reg unchanged.
  - Word read at 0x002 -> ERROR.
  - Read of 0x020 -> ERROR.
  - HSIZE=3 -> ERROR.
- STATUS and select gating: STATUS_IN=0xCAFEF00D, read 0x01C -> 0xCAFEF00D, OKAY. A transfer with HSEL=0 or HTRANS=BUSY/IDLE -> no wait, OKAY, no register change.
- WAIT_STATES=0 and WAIT_STATES=7 builds: a read data phase lasts exactly 1 and 8 cycles respectively, with HREADYOUT low for 0 and 7 cycles.

Source files
------------

// File: rtl/ahblite_regbank_slave.sv
// AHB-Lite register bank responder: NUM_REGS 32-bit registers, configurable
// data-phase wait states, two-cycle ERROR response, read-only STATUS at the top index.
module ahblite_regbank_slave #(
  parameter int WAIT_STATES = 1,
  parameter int NUM_REGS    = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  input  logic [31:0] STATUS_IN,
  output logic [31:0] REG0_OUT
);

  localparam int              IW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [2:0]      WS         = 3'(WAIT_STATES);
  localparam logic [IW-1:0]   STATUS_IDX = IW'(NUM_REGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t         r_state, w_state_nxt;
  logic [2:0]     r_cnt, w_cnt_nxt;
  logic           r_dp_vld;
  logic [IW-1:0]  r_idx;
  logic [1:0]     r_lane;
  logic [1:0]     r_size;
  logic           r_write;
  logic [31:0]    r_regs [NUM_REGS];

  logic           w_accept;
  logic           w_err;
  logic [9:0]     w_idx_full;
  logic           w_complete;
  logic           w_commit;
  logic           w_rd_phase;
  logic [3:0]     w_be;
  logic           w_unused;

  assign w_unused   = ^{HADDR[31:12], HTRANS[0]};
  assign w_idx_full = HADDR[11:2];

  // New address phases are only taken while this slave is not stalling the bus.
  assign w_accept = HSEL & HTRANS[1] & HREADY &
                    ((r_state == S_IDLE) | (r_state == S_ERR2));

  assign w_err = (HSIZE > 3'd2) ||
                 ((HSIZE == 3'd1) && HADDR[0]) ||
                 ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) ||
                 (w_idx_full >= 10'(NUM_REGS)) ||
                 (HWRITE && (w_idx_full == 10'(NUM_REGS - 1)));

  assign w_complete = (r_state == S_IDLE) & r_dp_vld;
  assign w_commit   = w_complete & r_write;
  assign w_rd_phase = r_dp_vld & ~r_write & ((r_state == S_IDLE) | (r_state == S_WAIT));

  always_comb begin
    w_be = 4'b1111;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_lane;
      2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    case (r_state)
      S_IDLE, S_ERR2: begin
        HRESP       = (r_state == S_ERR2);
        w_state_nxt = S_IDLE;
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = S_ERR1;
          end else if (WS != 3'd0) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WS;
          end
        end
      end
      S_WAIT: begin
        HREADYOUT = 1'b0;
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) w_state_nxt = S_IDLE;
      end
      S_ERR1: begin
        HREADYOUT   = 1'b0;
        HRESP       = 1'b1;
        w_state_nxt = S_ERR2;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Errored transfers never open an OKAY data phase, so they can never commit.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dp_vld <= 1'b0;
      r_idx    <= '0;
      r_lane   <= 2'b00;
      r_size   <= 2'b00;
      r_write  <= 1'b0;
    end else if (w_accept) begin
      r_dp_vld <= ~w_err;
      r_idx    <= HADDR[IW+1:2];
      r_lane   <= HADDR[1:0];
      r_size   <= HSIZE[1:0];
      r_write  <= HWRITE;
    end else if (w_complete) begin
      r_dp_vld <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 32'd0;
    end else if (w_commit) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (r_idx == IW'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_regs[i][8*b +: 8] <= HWDATA[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    HRDATA = 32'd0;
    if (w_rd_phase) HRDATA = (r_idx == STATUS_IDX) ? STATUS_IN : r_regs[r_idx];
  end

  assign REG0_OUT = r_regs[0];

endmodule

// File: tb/tb_ahblite_regbank_slave.sv
// Self-checking bench for ahblite_regbank_slave: directed scenarios plus randomized
// transfers against a byte-lane register model; three builds (1, 0 and 7 wait states).
module tb_ahblite_regbank_slave;

  localparam int NREG = 8;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] status_in;
  logic        hready_ovr;
  int          tgt;

  logic [2:0]  hsel_v, hready_v, rdy_v, resp_v;
  logic [31:0] rdata_v [3];
  logic [31:0] reg0_v  [3];
  logic        obs_rdy, obs_resp;
  logic [31:0] obs_rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mregs [3][NREG];

  always #5 HCLK = ~HCLK;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      hsel_v[k]   = hsel && (tgt == k);
      hready_v[k] = rdy_v[k] & ~hready_ovr;
    end
  end

  assign obs_rdy   = rdy_v[tgt];
  assign obs_resp  = resp_v[tgt];
  assign obs_rdata = rdata_v[tgt];

  ahblite_regbank_slave #(.WAIT_STATES(1), .NUM_REGS(NREG)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel_v[0]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready_v[0]),
    .HREADYOUT(rdy_v[0]), .HRESP(resp_v[0]), .HRDATA(rdata_v[0]),
    .STATUS_IN(status_in), .REG0_OUT(reg0_v[0]));

  ahblite_regbank_slave #(.WAIT_STATES(0), .NUM_REGS(NREG)) u_ws0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel_v[1]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready_v[1]),
    .HREADYOUT(rdy_v[1]), .HRESP(resp_v[1]), .HRDATA(rdata_v[1]),
    .STATUS_IN(status_in), .REG0_OUT(reg0_v[1]));

  ahblite_regbank_slave #(.WAIT_STATES(7), .NUM_REGS(NREG)) u_ws7 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel_v[2]), .HADDR(haddr), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready_v[2]),
    .HREADYOUT(rdy_v[2]), .HRESP(resp_v[2]), .HRDATA(rdata_v[2]),
    .STATUS_IN(status_in), .REG0_OUT(reg0_v[2]));

  // ---------------- reference model ----------------
  function automatic bit model_err(input logic [31:0] addr, input logic [2:0] size, input bit wr);
    int idx;
    idx = int'(addr[11:2]);
    return (size > 3'd2) || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00) ||
           (idx >= NREG) || (wr && idx == NREG - 1);
  endfunction

  function automatic logic [31:0] model_read(input int inst, input logic [31:0] addr);
    int idx;
    idx = int'(addr[11:2]);
    if (idx == NREG - 1) return status_in;
    return mregs[inst][idx];
  endfunction

  task automatic model_write(input int inst, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] data);
    int nbytes, base, idx, lane;
    nbytes = 1 << size;
    base   = (int'(addr[1:0]) / nbytes) * nbytes;
    idx    = int'(addr[11:2]);
    for (int k = 0; k < nbytes; k++) begin
      lane = base + k;
      mregs[inst][idx][lane*8 +: 8] = data[lane*8 +: 8];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < NREG; j++) mregs[i][j] = 32'd0;
  endtask

  // ---------------- bus driver (entered and left 1 time unit after a rising edge) ----------------
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic resp_end, output logic resp_low, output int nlow);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hsize = size; hwrite = wr;
    @(posedge HCLK); #1;
    htrans = 2'b00; hwdata = wdata;
    nlow = 0; resp_low = 1'b0; resp_end = 1'b0; rdata = 32'd0;
    for (int c = 0; c < 20; c++) begin
      @(negedge HCLK);
      if (obs_rdy) begin
        rdata = obs_rdata; resp_end = obs_resp;
        break;
      end
      nlow++;
      resp_low = obs_resp;
      @(posedge HCLK); #1;
    end
    @(posedge HCLK); #1;
    hsel = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd; logic re, rl; int nl;
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    checks++;
    if (rdy_v[0] !== 1'b1 || resp_v[0] !== 1'b0) begin
      failures++; $display("FAIL reset_handshake: ready=%b resp=%b expected 1 0", rdy_v[0], resp_v[0]);
    end
    checks++;
    if (rdata_v[0] !== 32'd0 || reg0_v[0] !== 32'd0) begin
      failures++; $display("FAIL reset_data: hrdata=%h reg0=%h expected 0 0", rdata_v[0], reg0_v[0]);
    end
    HRESET = 1'b0;
    model_reset();
    xfer(1'b1, 32'h0, 3'd2, 32'hA5A5A5A5, rd, re, rl, nl);
    model_write(0, 32'h0, 3'd2, 32'hA5A5A5A5);
    checks++;
    if (reg0_v[0] !== 32'hA5A5A5A5) begin
      failures++; $display("FAIL reg0_write: got %h expected a5a5a5a5", reg0_v[0]);
    end
    // Abort a write in its wait state.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hsize = 3'd2; hwrite = 1'b1;
    @(posedge HCLK); #1;
    htrans = 2'b00; hwdata = 32'h12345678;
    @(negedge HCLK);
    checks++;
    if (rdy_v[0] !== 1'b0) begin
      failures++; $display("FAIL reset_prewait: ready=%b expected 0", rdy_v[0]);
    end
    #1 HRESET = 1'b1;
    #1;
    checks++;
    if (rdy_v[0] !== 1'b1 || resp_v[0] !== 1'b0 || reg0_v[0] !== 32'd0) begin
      failures++;
      $display("FAIL reset_abort: ready=%b resp=%b reg0=%h expected 1 0 00000000", rdy_v[0], resp_v[0], reg0_v[0]);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0; hsel = 1'b0;
    model_reset();
    xfer(1'b0, 32'h0, 3'd2, 32'h0, rd, re, rl, nl);
    checks++;
    if (rd !== 32'd0 || re !== 1'b0 || nl != 1) begin
      failures++; $display("FAIL reset_readback: data=%h resp=%b low=%0d expected 0 0 1", rd, re, nl);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  seq;
    logic        any_resp;
    logic [31:0] rd;
    tgt = 0; any_resp = 1'b0; seq = 4'b0; rd = 32'd0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h4; hsize = 3'd2; hwrite = 1'b1;
    @(posedge HCLK); #1;
    hwdata = 32'hDEADBEEF; hwrite = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge HCLK);
      seq[k] = obs_rdy;
      any_resp |= obs_resp;
      if (k == 3) rd = obs_rdata;
      @(posedge HCLK); #1;
      if (k == 1) htrans = 2'b00;
    end
    hsel = 1'b0;
    model_write(0, 32'h4, 3'd2, 32'hDEADBEEF);
    checks++;
    if (seq !== 4'b1010) begin
      failures++; $display("FAIL b2b_ready_seq: got %b expected 1010 (cycle0 in lsb)", seq);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL b2b_readback: got %h expected deadbeef", rd);
    end
    checks++;
    if (any_resp !== 1'b0) begin
      failures++; $display("FAIL b2b_resp: got %b expected 0", any_resp);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic re, rl; int nl;
    tgt = 0;
    xfer(1'b1, 32'h008, 3'd2, 32'hFFFFFFFF, rd, re, rl, nl);
    model_write(0, 32'h008, 3'd2, 32'hFFFFFFFF);
    xfer(1'b1, 32'h00A, 3'd0, 32'h005A0000, rd, re, rl, nl);
    model_write(0, 32'h00A, 3'd0, 32'h005A0000);
    checks++;
    if (re !== 1'b0 || nl != 1) begin
      failures++; $display("FAIL byte_write_resp: resp=%b low=%0d expected 0 1", re, nl);
    end
    xfer(1'b1, 32'h008, 3'd1, 32'h00001234, rd, re, rl, nl);
    model_write(0, 32'h008, 3'd1, 32'h00001234);
    xfer(1'b0, 32'h008, 3'd2, 32'h0, rd, re, rl, nl);
    checks++;
    if (rd !== 32'hFF5A1234) begin
      failures++; $display("FAIL byte_lanes: got %h expected ff5a1234", rd);
    end
    checks++;
    if (rd !== model_read(0, 32'h008)) begin
      failures++; $display("FAIL byte_lanes_model: got %h expected %h", rd, model_read(0, 32'h008));
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [5] = '{32'h01C, 32'h002, 32'h020, 32'h000, 32'h001};
    logic [2:0]  sizes [5] = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd2};
    bit          wrs   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] rd; logic re, rl; int nl;
    tgt = 0;
    status_in = 32'h13572468;
    for (int i = 0; i < 5; i++) begin
      xfer(wrs[i], addrs[i], sizes[i], 32'h0BAD0BAD, rd, re, rl, nl);
      checks++;
      if (nl != 1 || rl !== 1'b1 || re !== 1'b1) begin
        failures++;
        $display("FAIL error_resp_%0d: low=%0d resp_low=%b resp_end=%b expected 1 1 1", i, nl, rl, re);
      end
    end
    checks++;
    if (reg0_v[0] !== mregs[0][0]) begin
      failures++; $display("FAIL error_no_write: reg0=%h expected %h", reg0_v[0], mregs[0][0]);
    end
    xfer(1'b0, 32'h01C, 3'd2, 32'h0, rd, re, rl, nl);
    checks++;
    if (rd !== 32'h13572468 || re !== 1'b0) begin
      failures++; $display("FAIL error_status_intact: data=%h resp=%b expected 13572468 0", rd, re);
    end
  endtask

  task automatic test_status_gating();
    logic [31:0] rd; logic re, rl; int nl;
    logic        gsel [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0]  gtr  [3] = '{2'b10, 2'b01, 2'b00};
    tgt = 0;
    status_in = 32'hCAFEF00D;
    xfer(1'b0, 32'h01C, 3'd2, 32'h0, rd, re, rl, nl);
    checks++;
    if (rd !== 32'hCAFEF00D || re !== 1'b0 || nl != 1) begin
      failures++; $display("FAIL status_read: data=%h resp=%b low=%0d expected cafef00d 0 1", rd, re, nl);
    end
    for (int g = 0; g < 4; g++) begin
      hsel = (g < 3) ? gsel[g] : 1'b1;
      htrans = (g < 3) ? gtr[g] : 2'b10;
      hready_ovr = (g == 3);
      haddr = 32'h0; hsize = 3'd2; hwrite = 1'b1;
      @(posedge HCLK); #1;
      hready_ovr = 1'b0; htrans = 2'b00; hwdata = $urandom;
      @(negedge HCLK);
      checks++;
      if (obs_rdy !== 1'b1 || obs_resp !== 1'b0 || obs_rdata !== 32'd0) begin
        failures++;
        $display("FAIL gating_%0d: ready=%b resp=%b data=%h expected 1 0 00000000", g, obs_rdy, obs_resp, obs_rdata);
      end
      @(posedge HCLK); #1;
      checks++;
      if (reg0_v[0] !== mregs[0][0]) begin
        failures++; $display("FAIL gating_nowrite_%0d: reg0=%h expected %h", g, reg0_v[0], mregs[0][0]);
      end
      hsel = 1'b0;
    end
  endtask

  task automatic test_wait_timing();
    logic [31:0] rd, wd; logic re, rl; int nl, ws;
    for (int t = 1; t < 3; t++) begin
      tgt = t;
      ws = (t == 1) ? 0 : 7;
      wd = $urandom;
      xfer(1'b1, 32'h00C, 3'd2, wd, rd, re, rl, nl);
      model_write(t, 32'h00C, 3'd2, wd);
      checks++;
      if (nl != ws || re !== 1'b0) begin
        failures++; $display("FAIL ws%0d_write: low=%0d resp=%b expected %0d 0", ws, nl, re, ws);
      end
      xfer(1'b0, 32'h00C, 3'd2, 32'h0, rd, re, rl, nl);
      checks++;
      if (nl != ws || re !== 1'b0) begin
        failures++; $display("FAIL ws%0d_read_len: low=%0d resp=%b expected %0d 0", ws, nl, re, ws);
      end
      checks++;
      if (rd !== model_read(t, 32'h00C)) begin
        failures++; $display("FAIL ws%0d_read_data: got %h expected %h", ws, rd, model_read(t, 32'h00C));
      end
    end
    tgt = 0;
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd; logic [2:0] sz; bit wr, e; logic re, rl; int nl;
    tgt = 0;
    for (int n = 0; n < 60; n++) begin
      sz = 3'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0)
        a[1:0] = (sz == 3'd0) ? a[1:0] : (sz == 3'd1) ? {a[1], 1'b0} : 2'b00;
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      status_in = $urandom;
      e = model_err(a, sz, wr);
      xfer(wr, a, sz, wd, rd, re, rl, nl);
      checks++;
      if (nl != 1 || re !== e || rl !== e) begin
        failures++;
        $display("FAIL rand_resp_%0d: addr=%h size=%0d wr=%0b low=%0d resp=%b/%b expected 1 %b/%b",
                 n, a, sz, wr, nl, rl, re, e, e);
      end
      if (!e && !wr) begin
        checks++;
        if (rd !== model_read(0, a)) begin
          failures++; $display("FAIL rand_read_%0d: addr=%h got %h expected %h", n, a, rd, model_read(0, a));
        end
      end
      if (!e && wr) model_write(0, a, sz, wd);
      checks++;
      if (reg0_v[0] !== mregs[0][0]) begin
        failures++; $display("FAIL rand_reg0_%0d: got %h expected %h", n, reg0_v[0], mregs[0][0]);
      end
    end
    for (int r = 0; r < NREG - 1; r++) begin
      xfer(1'b0, 32'(r * 4), 3'd2, 32'h0, rd, re, rl, nl);
      checks++;
      if (rd !== mregs[0][r]) begin
        failures++; $display("FAIL rand_final_reg%0d: got %h expected %h", r, rd, mregs[0][r]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hsize = 3'd2;
    hwrite = 1'b0; hwdata = 32'h0; status_in = 32'h0; hready_ovr = 1'b0; tgt = 0;
    model_reset();
    test_reset();
    test_back_to_back();
    test_byte_lanes();
    test_errors();
    test_status_gating();
    test_wait_timing();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
